// File: rtl/fetch_stage_if.sv
// Instruction-cache request/response channel between the fetch stage (master) and the icache (slave).
interface fetch_stage_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;

  modport master (output req_valid, req_addr, input req_ready, resp_valid, resp_data);
  modport slave  (input req_valid, req_addr, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one icache request in flight, and holds the
// returned word in a registered slot for decode. Redirects flush the slot and squash responses.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master ic,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  input  logic          stall,
  output logic          out_valid,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc,
  output logic [31:0]   fetched_count
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] WAIT  = 1'b1;

  typedef struct packed {
    logic        vld;
    logic [31:0] instr;
    logic [31:0] pc;
  } slot_t;

  logic [0:0]  state_q;
  logic        squash_q;
  logic [31:0] pc_q;
  logic [31:0] req_pc_q;
  logic [31:0] count_q;
  slot_t       slot_q;

  logic consume;
  logic slot_busy;
  logic hs;
  logic resp_in_wait;
  logic load;

  assign consume      = slot_q.vld && !stall;
  // Only ask for a new word when the slot is guaranteed to have room for it next cycle.
  assign slot_busy    = slot_q.vld && stall;
  assign ic.req_valid = rst_n && (state_q == FETCH) && !slot_busy && !redirect_valid;
  assign ic.req_addr  = pc_q;
  assign hs           = ic.req_valid && ic.req_ready;
  assign resp_in_wait = (state_q == WAIT) && ic.resp_valid;
  assign load         = resp_in_wait && !squash_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      squash_q <= 1'b0;
      pc_q     <= RESET_PC;
      req_pc_q <= 32'd0;
      count_q  <= 32'd0;
      slot_q   <= '0;
    end else begin
      // Decode consumes even when a redirect flushes the slot in the same cycle.
      count_q <= count_q + {31'd0, consume};
      if (redirect_valid) begin
        pc_q       <= {redirect_pc[31:2], 2'b00};
        slot_q.vld <= 1'b0;
        if (state_q == WAIT) begin
          if (ic.resp_valid) begin
            state_q  <= FETCH;
            squash_q <= 1'b0;
          end else begin
            squash_q <= 1'b1;
          end
        end
      end else begin
        if (hs) begin
          state_q  <= WAIT;
          req_pc_q <= pc_q;
          pc_q     <= pc_q + 32'(PC_STEP);
        end
        if (resp_in_wait) begin
          state_q  <= FETCH;
          squash_q <= 1'b0;
        end
        // A landing response wins over a same-cycle consume.
        if (load)
          slot_q <= '{vld: 1'b1, instr: ic.resp_data, pc: req_pc_q};
        else if (consume)
          slot_q.vld <= 1'b0;
      end
    end
  end

  assign out_valid     = slot_q.vld;
  assign out_instr     = slot_q.instr;
  assign out_pc        = slot_q.pc;
  assign fetched_count = count_q;

endmodule
